neur_aer_out_tx: RTL

//  Egress end of the neuron-event path. Captures spikes emitted by the neuron core (NEUR_EVENT_OUT[6]

---
 rtl/neur_aer_out_tx_pkg.sv | 15 +
 rtl/aer_evt_fifo.sv | 55 +++++
 rtl/neur_aer_out_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/neur_aer_out_tx_pkg.sv
// Shared definitions for the neuron-event egress path: AER handshake state
// encoding and the layout of the neuron core event word.
package neur_aer_out_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2
    } aer_tx_state_t;

    localparam int NEUR_EVT_SPIKE_BIT = 6;
    localparam int NEUR_EVT_W         = 7;
    localparam int AER_EVT_W          = 8;

endpackage

// File: rtl/aer_evt_fifo.sv
// Synchronous event FIFO; a push at full is accepted only when a pop
// frees a slot on the same edge.
module aer_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/neur_aer_out_tx.sv
// Neuron spike egress: buffers firing neuron addresses and sends them
// off-chip over a 4-phase AER REQ/ACK handshake with an asynchronous ACK.
//
//  state           | meaning
//  ST_IDLE         | no request out; start one when an event waits and ack_s is low
//  ST_REQ          | REQ high, ADDR held; ack_s high drops REQ and pops the event
//  ST_WAIT_ACK_LOW | REQ low, waiting for the receiver to release ACK
module neur_aer_out_tx
    import neur_aer_out_tx_pkg::*;
#(
    parameter int M          = AER_EVT_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN_syncn,
    input  logic                  SPI_GATE_ACTIVITY_sync,
    input  logic                  SPI_OVF_CLR,
    input  logic                  CTRL_NEURMEM_CS,
    input  logic                  CTRL_NEURMEM_WE,
    input  logic [M-1:0]          CTRL_NEURMEM_ADDR,
    input  logic [NEUR_EVT_W-1:0] NEUR_EVENT_OUT,
    output logic [M-1:0]          AEROUT_ADDR,
    output logic                  AEROUT_REQ,
    input  logic                  AEROUT_ACK,
    output logic                  AER_TX_FULL,
    output logic                  AER_TX_OVF
);
    aer_tx_state_t state_q;
    aer_tx_state_t state_d;

    logic         ack_m;
    logic         ack_s;
    logic         spike_push;
    logic         fifo_pop;
    logic         fifo_empty;
    logic         fifo_full;
    logic         fifo_drop;
    logic [M-1:0] fifo_head;
    logic         addr_load;
    logic         req_d;
    logic         evt_unused;

    assign evt_unused = ^NEUR_EVENT_OUT[NEUR_EVT_SPIKE_BIT-1:0];

    assign spike_push = CTRL_NEURMEM_CS & CTRL_NEURMEM_WE
                      & NEUR_EVENT_OUT[NEUR_EVT_SPIKE_BIT] & ~SPI_GATE_ACTIVITY_sync;

    aer_evt_fifo #(
        .WIDTH (M),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rstn  (RSTN_syncn),
        .push  (spike_push),
        .pop   (fifo_pop),
        .din   (CTRL_NEURMEM_ADDR),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign AER_TX_FULL = fifo_full;

    always_ff @(posedge CLK) begin
        if (!RSTN_syncn) begin
            ack_m      <= 1'b0;
            ack_s      <= 1'b0;
            AER_TX_OVF <= 1'b0;
        end else begin
            ack_m <= AEROUT_ACK;
            ack_s <= ack_m;
            // A drop on the same edge as a clear keeps the flag set.
            if (fifo_drop)        AER_TX_OVF <= 1'b1;
            else if (SPI_OVF_CLR) AER_TX_OVF <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN_syncn) begin
            state_q     <= ST_IDLE;
            AEROUT_REQ  <= 1'b0;
            AEROUT_ADDR <= '0;
        end else begin
            state_q    <= state_d;
            AEROUT_REQ <= req_d;
            if (addr_load) AEROUT_ADDR <= fifo_head;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:         if (!fifo_empty && !ack_s) state_d = ST_REQ;
            ST_REQ:          if (ack_s)                 state_d = ST_WAIT_ACK_LOW;
            ST_WAIT_ACK_LOW: if (!ack_s)                state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_load = (state_q == ST_IDLE) && (state_d == ST_REQ);
        fifo_pop  = (state_q == ST_REQ) && ack_s;
        req_d     = (state_d == ST_REQ);
    end

endmodule
